// File: rtl/movegen_pkg.sv
// Shared definitions for the move-generator driver: accelerator register map,
// piece ids, board geometry and the driver FSM state encoding.
package movegen_pkg;

  localparam logic [3:0] REG_START_RESULT = 4'd0;
  localparam logic [3:0] REG_BOARD        = 4'd1;
  localparam logic [3:0] REG_PIECE        = 4'd2;
  localparam logic [3:0] REG_OUT          = 4'd3;

  localparam int BOARD_BYTES = 64;

  // White ids run 1..48; black pieces use the negated id of the same piece.
  localparam logic signed [7:0] EMPTY    = 8'sd0;
  localparam logic signed [7:0] WPAWN0   = 8'sd1;
  localparam logic signed [7:0] WBISHOP0 = 8'sd29;
  localparam logic signed [7:0] WQUEEN0  = 8'sd39;
  localparam logic signed [7:0] WKING    = 8'sd48;
  localparam logic signed [7:0] BPAWN0   = -8'sd1;
  localparam logic signed [7:0] BBISHOP0 = -8'sd29;
  localparam logic signed [7:0] BQUEEN0  = -8'sd39;
  localparam logic signed [7:0] BKING    = -8'sd48;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_BOARD  = 3'd1,
    ST_WR_OUT    = 3'd2,
    ST_WR_PIECE  = 3'd3,
    ST_WR_START  = 3'd4,
    ST_RD_RESULT = 3'd5,
    ST_RESP      = 3'd6
  } state_e;

endpackage

// File: rtl/movegen_driver.sv
// Avalon-MM initiator that programs one move-generator accelerator per command,
// blocks on its result read and returns move count plus elapsed cycles.
module movegen_driver
  import movegen_pkg::*;
#(
  parameter int MAX_MOVES = 27,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_board_addr,
  input  logic [31:0]      cmd_out_addr,
  input  logic [7:0]       cmd_piece,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_count,
  output logic [CNT_W-1:0] rsp_cycles,
  output logic             rsp_err,
  output logic [3:0]       mg_address,
  output logic             mg_read,
  output logic             mg_write,
  output logic [31:0]      mg_writedata,
  input  logic [31:0]      mg_readdata,
  input  logic             mg_waitrequest
);

  localparam logic [31:0]      MAX_MOVES_W = 32'(MAX_MOVES);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [31:0]      board_q, board_d;
  logic [31:0]      out_q, out_d;
  logic [7:0]       piece_q, piece_d;
  logic [CNT_W-1:0] cycles_q, cycles_d, cycles_inc;
  logic [31:0]      count_q, count_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [3:0]       addr_q, addr_d;
  logic             read_q, read_d;
  logic             write_q, write_d;
  logic [31:0]      wdata_q, wdata_d;

  assign cycles_inc = (cycles_q == CNT_MAX) ? cycles_q : cycles_q + CNT_ONE;

  // Next-state, command latch, result capture and next-cycle bus decode.
  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    out_d    = out_q;
    piece_d  = piece_q;
    cycles_d = cycles_q;
    count_d  = count_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d  = ST_WR_BOARD;
          board_d  = cmd_board_addr;
          out_d    = cmd_out_addr;
          piece_d  = cmd_piece;
          cycles_d = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_BOARD: begin
        cycles_d = cycles_inc;
        state_d  = mg_waitrequest ? ST_WR_BOARD : ST_WR_OUT;
      end
      ST_WR_OUT: begin
        cycles_d = cycles_inc;
        state_d  = mg_waitrequest ? ST_WR_OUT : ST_WR_PIECE;
      end
      ST_WR_PIECE: begin
        cycles_d = cycles_inc;
        state_d  = mg_waitrequest ? ST_WR_PIECE : ST_WR_START;
      end
      ST_WR_START: begin
        cycles_d = cycles_inc;
        state_d  = mg_waitrequest ? ST_WR_START : ST_RD_RESULT;
      end
      ST_RD_RESULT: begin
        // The release edge freezes the counter rather than counting itself.
        if (!mg_waitrequest) begin
          state_d = ST_RESP;
          count_d = mg_readdata;
          err_d   = (mg_readdata > MAX_MOVES_W);
        end else begin
          cycles_d = cycles_inc;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    addr_d  = REG_START_RESULT;
    wdata_d = 32'h0000_0000;
    read_d  = 1'b0;
    write_d = 1'b0;
    case (state_d)
      ST_WR_BOARD: begin
        addr_d  = REG_BOARD;
        wdata_d = board_d;
        write_d = 1'b1;
      end
      ST_WR_OUT: begin
        addr_d  = REG_OUT;
        wdata_d = out_d;
        write_d = 1'b1;
      end
      ST_WR_PIECE: begin
        addr_d  = REG_PIECE;
        wdata_d = {{24{piece_d[7]}}, piece_d};
        write_d = 1'b1;
      end
      ST_WR_START: begin
        addr_d  = REG_START_RESULT;
        wdata_d = 32'h0000_0001;
        write_d = 1'b1;
      end
      ST_RD_RESULT: begin
        addr_d = REG_START_RESULT;
        read_d = 1'b1;
      end
      default: begin
        addr_d = REG_START_RESULT;
      end
    endcase
    valid_d = (state_d == ST_RESP);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      board_q  <= 32'h0000_0000;
      out_q    <= 32'h0000_0000;
      piece_q  <= 8'h00;
      cycles_q <= {CNT_W{1'b0}};
      count_q  <= 32'h0000_0000;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      addr_q   <= 4'd0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      out_q    <= out_d;
      piece_q  <= piece_d;
      cycles_q <= cycles_d;
      count_q  <= count_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      read_q   <= read_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = valid_q;
  assign rsp_count    = count_q;
  assign rsp_cycles   = cycles_q;
  assign rsp_err      = err_q;
  assign mg_address   = addr_q;
  assign mg_read      = read_q;
  assign mg_write     = write_q;
  assign mg_writedata = wdata_q;

endmodule
